// File: rtl/key_filter_bank.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : key_filter_bank
// Purpose  : Multi-channel push-button debouncer in the Sys_CLK domain.
//            A shared divider produces a one-cycle sample tick. Each channel
//            synchronises its raw pin through two flops and accepts a new
//            level only after STABLE_TICKS consecutive ticks of disagreement.
//            It produces a clean level plus one-cycle press/release strobes.
// Ports    : Sys_CLK     - system clock, rising edge
//            Sys_RST_n   - asynchronous active-low reset
//            Key_In      - raw asynchronous key pins [N_KEYS]
//            Key_Out     - debounced level, 1 = pressed [N_KEYS]
//            Key_Press   - one-cycle strobe on Key_Out 0->1 [N_KEYS]
//            Key_Release - one-cycle strobe on Key_Out 1->0 [N_KEYS]
//            Key_Long    - one-cycle long-press strobe [N_KEYS]
//            Tick        - shared sample-tick enable
// Options  : define KEY_FILTER_LONGPRESS_EN to build the long-press counters;
//            without it Key_Long is a constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module key_filter_bank #(
    parameter int N_KEYS       = 2,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 12,
    parameter int ACTIVE_LOW   = 1,
    parameter int LONG_TICKS   = 1000
) (
    input  logic              Sys_CLK,
    input  logic              Sys_RST_n,
    input  logic [N_KEYS-1:0] Key_In,
    output logic [N_KEYS-1:0] Key_Out,
    output logic [N_KEYS-1:0] Key_Press,
    output logic [N_KEYS-1:0] Key_Release,
    output logic [N_KEYS-1:0] Key_Long,
    output logic              Tick
);

    localparam int                 c_DIV_W      = $clog2(TICK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(TICK_DIV - 1);
    localparam int                 c_STB_W      = $clog2(STABLE_TICKS + 1);
    localparam logic [c_STB_W-1:0] c_STB_LAST   = c_STB_W'(STABLE_TICKS - 1);
    // Raw pin level of a key that is not pressed.
    localparam logic               c_RELEASED   = (ACTIVE_LOW != 0);

    if (N_KEYS < 1 || TICK_DIV < 2 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_param
        $error("key_filter_bank: illegal parameter value");
    end

    // ------------------------------------------------------------------------
    // Shared tick divider. Tick is registered, so it is loaded from the
    // counter's next value: it is high exactly while the counter holds
    // TICK_DIV-1.
    // ------------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_DIV_W-1:0] w_div_next;
    logic               r_tick;

    assign w_div_next = (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + 1'b1;

    always_ff @(posedge Sys_CLK or negedge Sys_RST_n) begin
        if (!Sys_RST_n) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_tick    <= (w_div_next == c_DIV_LAST);
        end
    end

    assign Tick = r_tick;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser. Both stages reset to the released pin level so
    // that leaving reset never looks like a key edge.
    // ------------------------------------------------------------------------
    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [N_KEYS-1:0] w_sample;

    always_ff @(posedge Sys_CLK or negedge Sys_RST_n) begin
        if (!Sys_RST_n) begin
            r_sync1 <= {N_KEYS{c_RELEASED}};
            r_sync2 <= {N_KEYS{c_RELEASED}};
        end else begin
            r_sync1 <= Key_In;
            r_sync2 <= r_sync1;
        end
    end

    // Normalised so that 1 always means pressed.
    assign w_sample = r_sync2 ^ {N_KEYS{c_RELEASED}};

    // ------------------------------------------------------------------------
    // Per-channel stability filter and strobes.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
        logic [c_STB_W-1:0] r_stb_cnt;
        logic               r_out;
        logic               r_press;
        logic               r_release;
        logic               w_differ;
        logic               w_accept;

        assign w_differ = w_sample[gi] ^ r_out;
        // The tick that completes STABLE_TICKS of disagreement flips the level.
        assign w_accept = w_differ & r_tick & (r_stb_cnt == c_STB_LAST);

        always_ff @(posedge Sys_CLK or negedge Sys_RST_n) begin
            if (!Sys_RST_n) begin
                r_stb_cnt <= '0;
                r_out     <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= w_accept & ~r_out;
                r_release <= w_accept & r_out;
                if (!w_differ) begin
                    // Any agreement, even between ticks, restarts filtering.
                    r_stb_cnt <= '0;
                end else if (r_tick) begin
                    if (w_accept) begin
                        r_stb_cnt <= '0;
                        r_out     <= ~r_out;
                    end else begin
                        r_stb_cnt <= r_stb_cnt + 1'b1;
                    end
                end
            end
        end

        assign Key_Out[gi]     = r_out;
        assign Key_Press[gi]   = r_press;
        assign Key_Release[gi] = r_release;

`ifdef KEY_FILTER_LONGPRESS_EN
        localparam int                 c_LNG_W    = $clog2(LONG_TICKS + 1);
        localparam logic [c_LNG_W-1:0] c_LNG_LAST = c_LNG_W'(LONG_TICKS - 1);
        localparam logic [c_LNG_W-1:0] c_LNG_MAX  = c_LNG_W'(LONG_TICKS);

        logic [c_LNG_W-1:0] r_long_cnt;
        logic               r_long;

        // The counter saturates at LONG_TICKS, which is what prevents any
        // auto-repeat; only a release (level back to 0) re-arms it.
        always_ff @(posedge Sys_CLK or negedge Sys_RST_n) begin
            if (!Sys_RST_n) begin
                r_long_cnt <= '0;
                r_long     <= 1'b0;
            end else begin
                r_long <= 1'b0;
                if (!r_out) begin
                    r_long_cnt <= '0;
                end else if (r_tick && (r_long_cnt != c_LNG_MAX)) begin
                    r_long_cnt <= r_long_cnt + 1'b1;
                    // Suppressed if the key is being released on this tick.
                    r_long     <= (r_long_cnt == c_LNG_LAST) & ~w_accept;
                end
            end
        end

        assign Key_Long[gi] = r_long;
`else
        assign Key_Long[gi] = 1'b0;
`endif
    end

endmodule
`default_nettype wire
